dff_pipe: RTL and testbench

//   Parametrised pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.

---
 rtl/dff_pipe.sv | 87 ++++++++
 tb/tb_dff_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - parametrised valid-tagged pipeline register with stall, flush and occupancy count
module dff_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               RST_DATA = 1'b1,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] q_o,
    output logic [CW-1:0]    count_o,
    output logic             busy_o
);

    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             advance;

    // Flush outranks enable, so data only moves on an enabled, non-flushed edge.
    assign advance = en_i & ~flush_i;

    // Valid shift chain and running occupancy; the count is maintained incrementally
    // (one word may enter and one may leave per edge) so it never needs a popcount tree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (en_i) begin
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            count_q <= count_q + CW'(valid_i) - CW'(valid_q[DEPTH-1]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        logic             stage_ld;
        logic [WIDTH-1:0] data_r;

        // A stage only loads when the word arriving at it is valid, so bubbles leave data flops untouched.
        if (k == 0) begin : g_head
            assign stage_d  = d_i;
            assign stage_ld = advance & valid_i;
        end else begin : g_body
            assign stage_d  = stage_q[k-1];
            assign stage_ld = advance & valid_q[k-1];
        end

        if (RST_DATA) begin : g_rst
            // Data stage with a known reset value.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_r <= RST_VAL;
                end else if (stage_ld) begin
                    data_r <= stage_d;
                end
            end
        end else begin : g_nrst
            // Data stage without reset; contents are meaningless until its valid bit is set.
            always_ff @(posedge clk) begin
                if (stage_ld) begin
                    data_r <= stage_d;
                end
            end
        end

        assign stage_q[k] = data_r;
    end

    assign valid_o = valid_q[DEPTH-1];
    assign q_o     = stage_q[DEPTH-1];
    assign count_o = count_q;
    assign busy_o  = (count_q != '0);

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - self-checking bench for dff_pipe: vector table, scoreboard, async reset, random soak
module tb_dff_pipe;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       flush;
    logic       vin;
    logic [7:0] d;

    logic       valid_o,  nr_valid;
    logic [7:0] q_o,      nr_q;
    logic [1:0] count_o,  nr_count;
    logic       busy_o,   nr_busy;

    int checks   = 0;
    int failures = 0;

    dff_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(8'hA5), .RST_DATA(1'b1)) u_dut (
        .clk(clk), .reset(reset), .en_i(en), .flush_i(flush), .valid_i(vin), .d_i(d),
        .valid_o(valid_o), .q_o(q_o), .count_o(count_o), .busy_o(busy_o)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(8'h00), .RST_DATA(1'b0)) u_nr (
        .clk(clk), .reset(reset), .en_i(en), .flush_i(flush), .valid_i(vin), .d_i(d),
        .valid_o(nr_valid), .q_o(nr_q), .count_o(nr_count), .busy_o(nr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         edge_no;
    } sb_t;

    sb_t sbq[$];
    int  edge_no = 0;

    typedef struct {
        logic       en;
        logic       flush;
        logic       vin;
        logic [7:0] d;
        logic       ev;
        logic [7:0] eq;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted word remembers the enabled-edge number it entered on;
    // it is visible on the output after DEPTH-1 further enabled edges and leaves on the next.
    task automatic model_edge();
        if (reset || flush) begin
            sbq.delete();
        end else if (en) begin
            sb_t w;
            edge_no++;
            if (sbq.size() > 0 && sbq[0].edge_no + DEPTH <= edge_no) begin
                void'(sbq.pop_front());
            end
            if (vin) begin
                w.data    = d;
                w.edge_no = edge_no;
                sbq.push_back(w);
            end
        end
    endtask

    task automatic sb_check(input string tag);
        logic       ev;
        logic [1:0] ec;
        ec = 2'(sbq.size());
        ev = (sbq.size() > 0) && (sbq[0].edge_no + DEPTH - 1 == edge_no);
        chk({tag, "_valid"},    32'(valid_o),  32'(ev));
        chk({tag, "_count"},    32'(count_o),  32'(ec));
        chk({tag, "_busy"},     32'(busy_o),   32'(ec != 2'd0));
        chk({tag, "_nr_valid"}, 32'(nr_valid), 32'(ev));
        chk({tag, "_nr_count"}, 32'(nr_count), 32'(ec));
        chk({tag, "_nr_busy"},  32'(nr_busy),  32'(ec != 2'd0));
        if (ev) begin
            chk({tag, "_q"},    32'(q_o),  32'(sbq[0].data));
            chk({tag, "_nr_q"}, 32'(nr_q), 32'(sbq[0].data));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        sb_check(tag);
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [7:0] dd);
        en    = e;
        flush = f;
        vin   = v;
        d     = dd;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Vector table: {en, flush, valid_i, d_i, exp valid_o, exp q_o, exp count_o}
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'hA5, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'hA5, 2'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 8'h01, 2'd3});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 8'h02, 2'd3});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 2'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 2'd0});
        // 11, bubble, 22, then four stalled cycles with junk on the inputs
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h04, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 8'h11, 2'd2});
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 8'h11, 2'd2});
        end
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 2'd0});
        // fill to 3, flush with FF offered; FF must never appear
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 8'h22, 2'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h32, 1'b0, 8'h22, 2'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'h31, 2'd3});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h31, 2'd0});
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h31, 2'd0});
        end
        // flush wins over a stall
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 8'h31, 2'd1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h31, 2'd0});
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h31, 2'd0});
        end

        // Reset and idle state
        step("rst0");
        step("rst1");
        reset = 1'b0;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_q",     32'(q_o),     32'hA5);
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_busy",  32'(busy_o),  32'd0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step("idle0");
        step("idle1");
        chk("idle_q", 32'(q_o), 32'hA5);

        // Table-driven directed vectors
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].vin, vecs[i].d);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_valid", i), 32'(valid_o), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_tbl_q", i),     32'(q_o),     32'(vecs[i].eq));
            chk($sformatf("vec%0d_tbl_count", i), 32'(count_o), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_tbl_busy", i),  32'(busy_o),  32'(vecs[i].ec != 2'd0));
        end

        // Asynchronous reset between edges with two words in flight
        drive(1'b1, 1'b0, 1'b1, 8'h51);
        step("ar0");
        drive(1'b1, 1'b0, 1'b1, 8'h52);
        step("ar1");
        chk("ar_pre_count", 32'(count_o), 32'd2);
        drive(1'b1, 1'b0, 1'b1, 8'h53);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",    32'(valid_o),  32'd0);
        chk("ar_count",    32'(count_o),  32'd0);
        chk("ar_busy",     32'(busy_o),   32'd0);
        chk("ar_q",        32'(q_o),      32'hA5);
        chk("ar_nr_valid", 32'(nr_valid), 32'd0);
        chk("ar_nr_count", 32'(nr_count), 32'd0);
        sbq.delete();
        step("ar_hold");
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step("ar_post");
        end
        chk("ar_post_q", 32'(q_o), 32'hA5);

        // Random soak: en, valid and flush random; scoreboard checks both instances each cycle
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 32) == 0, $urandom % 2 == 1, 8'($urandom));
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
